// File: rtl/alu_sequencer_if.sv
// Request/response channel between a client and alu_sequencer.
// The client side uses the master modport and the sequencer uses the slave modport.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [31:0] resp_aux;
  logic        resp_div_by_zero;

  modport master (
    output req_valid, req_opcode, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_aux, resp_div_by_zero
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_aux, resp_div_by_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencer in front of an external combinational 32-bit ALU (ADD/AND/NOT/OR only).
// It builds SUB, XOR, MUL (shift-add) and DIV (restoring) from multiple ALU passes.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  alu_sequencer_if.slave     io_seq,
  output logic [WIDTH-1:0]   o_alu_a,
  output logic [WIDTH-1:0]   o_alu_b,
  output logic [2:0]         o_alu_opcode,
  output logic [WIDTH-1:0]   o_alu_carry_in,
  input  logic [WIDTH-1:0]   i_alu_output,
  input  logic [WIDTH-1:0]   i_alu_carry_out
);
  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000, OP_AND = 3'b001, OP_MUL = 3'b010, OP_NOT = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100, OP_OR  = 3'b101, OP_DIV = 3'b110, OP_XOR = 3'b111;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_x, r_y, r_t2;
  logic [5:0]       r_cnt;
  logic             r_req_ready, r_resp_valid, r_resp_dbz;
  logic [WIDTH-1:0] r_resp_result, r_resp_aux;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;
  logic [2:0]       r_alu_op;
  logic             r_alu_cin;

  logic [5:0]       w_last;
  logic             w_busy, w_co, w_iter_req;
  logic [WIDTH-1:0] w_shift, w_x_n, w_y_n, w_t2_n;
  logic [WIDTH-1:0] w_alu_a_n, w_alu_b_n, w_result_n, w_aux_n;
  logic [2:0]       w_alu_op_n;
  logic             w_alu_cin_n, w_dbz_n;
  logic             w_unused_carry;

  assign w_unused_carry = ^i_alu_carry_out[WIDTH-1:1];
  assign w_co           = i_alu_carry_out[0];
  assign w_busy         = (r_state == EXEC) || (r_state == ITER);
  assign w_shift        = {r_x[WIDTH-2:0], r_y[WIDTH-1]};
  assign w_iter_req     = (io_seq.req_opcode == OP_MUL) || (io_seq.req_opcode == OP_XOR) ||
                          ((io_seq.req_opcode == OP_DIV) && (io_seq.req_b != '0));

  // r_cnt counts captured passes; pass r_cnt is set up while the previous one is captured.
  always_comb begin
    w_last = (r_state == EXEC) ? 6'd1 : (r_op == OP_XOR) ? 6'd4 : 6'(WIDTH);
    w_x_n  = r_x;
    w_y_n  = r_y;
    w_t2_n = r_t2;
    if ((r_state == ITER) && (r_cnt != 6'd0)) begin
      case (r_op)
        OP_MUL: begin
          w_x_n = {w_co, i_alu_output[WIDTH-1:1]};
          w_y_n = {i_alu_output[0], r_y[WIDTH-1:1]};
        end
        OP_DIV: begin
          if (r_x[WIDTH-1] || w_co) begin
            w_x_n = i_alu_output;
            w_y_n = {r_y[WIDTH-2:0], 1'b1};
          end else begin
            w_x_n = w_shift;
            w_y_n = {r_y[WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          if (r_cnt == 6'd3) w_t2_n = i_alu_output;
          else               w_x_n  = i_alu_output;
        end
      endcase
    end

    w_alu_a_n   = '0;
    w_alu_b_n   = '0;
    w_alu_op_n  = OP_ADD;
    w_alu_cin_n = 1'b0;
    if (w_busy && (r_cnt != w_last)) begin
      case (r_op)
        OP_ADD: begin w_alu_a_n = r_a; w_alu_b_n = r_b; end
        OP_SUB: begin w_alu_a_n = r_a; w_alu_b_n = ~r_b; w_alu_cin_n = 1'b1; end
        OP_AND: begin w_alu_op_n = OP_AND; w_alu_a_n = r_a; w_alu_b_n = r_b; end
        OP_OR:  begin w_alu_op_n = OP_OR;  w_alu_a_n = r_a; w_alu_b_n = r_b; end
        OP_NOT: begin w_alu_op_n = OP_NOT; w_alu_a_n = r_a; end
        OP_MUL: begin
          w_alu_a_n = w_x_n;
          w_alu_b_n = w_y_n[0] ? r_b : '0;
        end
        OP_DIV: begin
          if (r_state == ITER) begin
            w_alu_a_n   = {w_x_n[WIDTH-2:0], w_y_n[WIDTH-1]};
            w_alu_b_n   = ~r_b;
            w_alu_cin_n = 1'b1;
          end
        end
        default: begin
          case (r_cnt)
            6'd0:    begin w_alu_op_n = OP_AND; w_alu_a_n = r_a;   w_alu_b_n = r_b;    end
            6'd1:    begin w_alu_op_n = OP_NOT; w_alu_a_n = w_x_n;                     end
            6'd2:    begin w_alu_op_n = OP_OR;  w_alu_a_n = r_a;   w_alu_b_n = r_b;    end
            default: begin w_alu_op_n = OP_AND; w_alu_a_n = w_x_n; w_alu_b_n = w_t2_n; end
          endcase
        end
      endcase
    end

    w_result_n = i_alu_output;
    w_aux_n    = '0;
    w_dbz_n    = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: w_aux_n = {{(WIDTH-1){1'b0}}, w_co};
      OP_MUL: begin w_result_n = w_y_n; w_aux_n = w_x_n; end
      OP_DIV: begin
        if (r_state == EXEC) begin
          w_result_n = '1;
          w_aux_n    = r_a;
          w_dbz_n    = 1'b1;
        end else begin
          w_result_n = w_y_n;
          w_aux_n    = w_x_n;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_op          <= OP_ADD;
      r_a           <= '0;
      r_b           <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_t2          <= '0;
      r_cnt         <= 6'd0;
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
      r_resp_aux    <= '0;
      r_resp_dbz    <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= OP_ADD;
      r_alu_cin     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_seq.req_valid && r_req_ready) begin
            r_op        <= io_seq.req_opcode;
            r_a         <= io_seq.req_a;
            r_b         <= io_seq.req_b;
            r_x         <= '0;
            r_y         <= io_seq.req_a;
            r_t2        <= '0;
            r_cnt       <= 6'd0;
            r_req_ready <= 1'b0;
            r_state     <= w_iter_req ? ITER : EXEC;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        EXEC, ITER: begin
          r_alu_a   <= w_alu_a_n;
          r_alu_b   <= w_alu_b_n;
          r_alu_op  <= w_alu_op_n;
          r_alu_cin <= w_alu_cin_n;
          r_x       <= w_x_n;
          r_y       <= w_y_n;
          r_t2      <= w_t2_n;
          r_cnt     <= r_cnt + 6'd1;
          if (r_cnt == w_last) begin
            r_state       <= DONE;
            r_resp_valid  <= 1'b1;
            r_resp_result <= w_result_n;
            r_resp_aux    <= w_aux_n;
            r_resp_dbz    <= w_dbz_n;
          end
        end
        default: begin
          if (io_seq.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign io_seq.req_ready        = r_req_ready;
  assign io_seq.resp_valid       = r_resp_valid;
  assign io_seq.resp_result      = r_resp_result;
  assign io_seq.resp_aux         = r_resp_aux;
  assign io_seq.resp_div_by_zero = r_resp_dbz;
  assign o_alu_a                 = r_alu_a;
  assign o_alu_b                 = r_alu_b;
  assign o_alu_opcode            = r_alu_op;
  assign o_alu_carry_in          = {{(WIDTH-1){1'b0}}, r_alu_cin};
endmodule
